// File: rtl/tlb_pkg.sv
// Shared types and helpers for the joint TLB: entry layout, op encoding,
// lookup result and the segment/translation rule used by both I and D ports.
package tlb_pkg;

    localparam int VPN2_W = 19;
    localparam int ASID_W = 8;
    localparam int MASK_W = 12;
    localparam int PFN_W  = 20;
    localparam int IDX_W  = 8;      // wide enough for any supported entry count

    // vaddr[31:30] == 2'b10 selects kseg0/kseg1 (unmapped); vaddr[29] picks kseg1
    localparam logic [1:0]  SEG_UNMAPPED   = 2'b10;
    localparam logic [31:0] SEG_PADDR_MASK = 32'h1FFF_FFFF;
    localparam logic [2:0]  CACHE_CACHED   = 3'd3;

    typedef enum logic [1:0] {
        OP_TLBR  = 2'd0,
        OP_TLBWI = 2'd1,
        OP_TLBWR = 2'd2,
        OP_TLBP  = 2'd3
    } tlb_op_t;

    typedef struct packed {
        logic [VPN2_W-1:0] vpn2;
        logic [ASID_W-1:0] asid;
        logic              g;
        logic [MASK_W-1:0] mask;
        logic [PFN_W-1:0]  pfn0;
        logic [2:0]        c0;
        logic              d0;
        logic              v0;
        logic [PFN_W-1:0]  pfn1;
        logic [2:0]        c1;
        logic              d1;
        logic              v1;
    } tlb_entry_t;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
        logic [PFN_W-1:0] pfn;
        logic [2:0]       c;
        logic             d;
        logic             v;
    } tlb_result_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        refill;
        logic        invalid;
        logic        modified;
        logic        cached;
    } tlb_xlate_t;

    // Turns a match result into a physical address plus exception flags.
    // Flags are mutually exclusive so refill > invalid > modified holds trivially.
    function automatic tlb_xlate_t tlb_translate(
        input logic [31:0]      vaddr,
        input logic             hit,
        input logic [PFN_W-1:0] pfn,
        input logic [2:0]       c,
        input logic             d,
        input logic             v,
        input logic             store
    );
        tlb_xlate_t x;
        x = '0;
        if (vaddr[31:30] == SEG_UNMAPPED) begin
            x.paddr  = vaddr & SEG_PADDR_MASK;
            x.cached = ~vaddr[29];
        end else if (!hit) begin
            x.refill = 1'b1;
        end else begin
            x.paddr    = {pfn, vaddr[11:0]};
            x.invalid  = ~v;
            x.modified = v & store & ~d;
            x.cached   = (c == CACHE_CACHED);
        end
        return x;
    endfunction

endpackage

// File: rtl/tlb_match.sv
// Fully parallel VPN2/ASID compare over every entry, lowest index wins.
// Purely combinational; the caller registers whatever it needs.
module tlb_match
    import tlb_pkg::*;
#(
    parameter int N_ENTRIES = 32
) (
    input  tlb_entry_t          entries [N_ENTRIES],
    input  logic [VPN2_W-1:0]   vpn2,
    input  logic [ASID_W-1:0]   asid,
    input  logic                odd,
    output tlb_result_t         result
);

    logic [N_ENTRIES-1:0] hit_vec;
    logic [N_ENTRIES-1:0] unused_mask_bits;

    generate
        for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_cmp
            assign hit_vec[gi] = (entries[gi].vpn2 == vpn2) &&
                                 (entries[gi].g || (entries[gi].asid == asid));
            // PageMask is stored for TLBR only; matching assumes 4 KB pages
            assign unused_mask_bits[gi] = ^entries[gi].mask;
        end
    endgenerate

    // Priority encode from the top down so the lowest hitting index is written last
    always_comb begin
        result = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                result.hit = 1'b1;
                result.idx = IDX_W'(i);
                result.pfn = odd ? entries[i].pfn1 : entries[i].pfn0;
                result.c   = odd ? entries[i].c1   : entries[i].c0;
                result.d   = odd ? entries[i].d1   : entries[i].d0;
                result.v   = odd ? entries[i].v1   : entries[i].v0;
            end
        end
    end

endmodule

// File: rtl/tlb_unit.sv
// Joint TLB: executes TLBR/TLBWI/TLBWR/TLBP for CP0 through a three-state op
// FSM and serves registered I-side and D-side translations in parallel.
module tlb_unit
    import tlb_pkg::*;
#(
    parameter int TLB_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid_i,
    input  logic [1:0]           op_i,
    output logic                 busy_o,
    output logic                 op_done_o,
    input  logic [31:0]          index_i,
    input  logic [31:0]          entryhi_i,
    input  logic [31:0]          pagemask_i,
    input  logic [31:0]          entrylo0_i,
    input  logic [31:0]          entrylo1_i,
    output logic                 result_we_o,
    output logic                 result_index_we_o,
    output logic [31:0]          result_index_o,
    output logic [31:0]          result_entryhi_o,
    output logic [31:0]          result_pagemask_o,
    output logic [31:0]          result_entrylo0_o,
    output logic [31:0]          result_entrylo1_o,
    output logic [TLB_WIDTH-1:0] random_o,
    input  logic                 i_req_i,
    input  logic                 d_req_i,
    input  logic [31:0]          i_vaddr_i,
    input  logic [31:0]          d_vaddr_i,
    input  logic                 d_store_i,
    output logic [31:0]          i_paddr_o,
    output logic [31:0]          d_paddr_o,
    output logic                 i_valid_o,
    output logic                 d_valid_o,
    output logic                 i_refill_o,
    output logic                 d_refill_o,
    output logic                 i_invalid_o,
    output logic                 d_invalid_o,
    output logic                 d_modified_o,
    output logic                 i_cached_o,
    output logic                 d_cached_o
);

    localparam int N_ENTRIES = 1 << TLB_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    tlb_op_t              op_in;
    tlb_op_t              op_reg;
    logic [TLB_WIDTH-1:0] idx_reg;
    logic [TLB_WIDTH-1:0] random_reg;
    logic [VPN2_W-1:0]    hi_vpn2_reg;
    logic [ASID_W-1:0]    hi_asid_reg;
    logic [MASK_W-1:0]    mask_reg;
    logic [25:0]          lo0_reg, lo1_reg;
    tlb_entry_t           entries_reg [N_ENTRIES];
    tlb_entry_t           new_entry;
    tlb_entry_t           rd_entry;
    logic                 accept;
    logic                 write_en;
    tlb_result_t          probe_res, i_res, d_res;
    logic [31:0]          probe_index;
    tlb_xlate_t           i_x_reg, d_x_reg;
    logic                 i_valid_reg, d_valid_reg;
    logic [31:0]          res_index_reg, res_hi_reg, res_mask_reg, res_lo0_reg, res_lo1_reg;

    assign op_in    = tlb_op_t'(op_i);
    assign accept   = (state_reg == ST_IDLE) && op_valid_i;
    assign write_en = (state_reg == ST_EXEC) && ((op_reg == OP_TLBWI) || (op_reg == OP_TLBWR));
    assign rd_entry = entries_reg[idx_reg];

    // Free-running random index: counts down and wraps through all entries
    always_ff @(posedge clk) begin
        if (rst) random_reg <= '1;
        else     random_reg <= random_reg - 1'b1;
    end

    // Capture the op and a snapshot of the CP0 operands when an op is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg      <= OP_TLBR;
            idx_reg     <= '0;
            hi_vpn2_reg <= '0;
            hi_asid_reg <= '0;
            mask_reg    <= '0;
            lo0_reg     <= '0;
            lo1_reg     <= '0;
        end else if (accept) begin
            op_reg      <= op_in;
            idx_reg     <= (op_in == OP_TLBWR) ? random_reg : index_i[TLB_WIDTH-1:0];
            hi_vpn2_reg <= entryhi_i[31:13];
            hi_asid_reg <= entryhi_i[7:0];
            mask_reg    <= pagemask_i[24:13];
            lo0_reg     <= entrylo0_i[25:0];
            lo1_reg     <= entrylo1_i[25:0];
        end
    end

    // Build the entry image from the latched EntryHi/PageMask/EntryLo words
    always_comb begin
        new_entry      = '0;
        new_entry.vpn2 = hi_vpn2_reg;
        new_entry.asid = hi_asid_reg;
        new_entry.g    = lo0_reg[0] & lo1_reg[0];
        new_entry.mask = mask_reg;
        new_entry.pfn0 = lo0_reg[25:6];
        new_entry.c0   = lo0_reg[5:3];
        new_entry.d0   = lo0_reg[2];
        new_entry.v0   = lo0_reg[1];
        new_entry.pfn1 = lo1_reg[25:6];
        new_entry.c1   = lo1_reg[5:3];
        new_entry.d1   = lo1_reg[2];
        new_entry.v1   = lo1_reg[1];
    end

    generate
        for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_entry
            // One register bank per entry; written at the end of EXEC unless reset aborts
            always_ff @(posedge clk) begin
                if (rst)                                            entries_reg[gi] <= '0;
                else if (write_en && (idx_reg == TLB_WIDTH'(gi)))   entries_reg[gi] <= new_entry;
            end
        end
    endgenerate

    // Op FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Op FSM next state and CP0 handshake outputs
    always_comb begin
        state_next        = state_reg;
        busy_o            = 1'b0;
        op_done_o         = 1'b0;
        result_we_o       = 1'b0;
        result_index_we_o = 1'b0;
        case (state_reg)
            ST_IDLE: if (op_valid_i) state_next = ST_EXEC;
            ST_EXEC: begin
                busy_o     = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                busy_o            = 1'b1;
                op_done_o         = 1'b1;
                result_we_o       = (op_reg == OP_TLBR) || (op_reg == OP_TLBP);
                result_index_we_o = (op_reg == OP_TLBP);
                state_next        = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    tlb_match #(.N_ENTRIES(N_ENTRIES)) u_match_probe (
        .entries (entries_reg),
        .vpn2    (hi_vpn2_reg),
        .asid    (hi_asid_reg),
        .odd     (1'b0),
        .result  (probe_res)
    );

    tlb_match #(.N_ENTRIES(N_ENTRIES)) u_match_i (
        .entries (entries_reg),
        .vpn2    (i_vaddr_i[31:13]),
        .asid    (entryhi_i[7:0]),
        .odd     (i_vaddr_i[12]),
        .result  (i_res)
    );

    tlb_match #(.N_ENTRIES(N_ENTRIES)) u_match_d (
        .entries (entries_reg),
        .vpn2    (d_vaddr_i[31:13]),
        .asid    (entryhi_i[7:0]),
        .odd     (d_vaddr_i[12]),
        .result  (d_res)
    );

    // TLBP result word: P set on miss, index in the low bits on hit
    always_comb begin
        probe_index                  = '0;
        probe_index[31]              = ~probe_res.hit;
        probe_index[TLB_WIDTH-1:0]   = probe_res.idx[TLB_WIDTH-1:0];
    end

    // TLBP/TLBR results are computed in EXEC and held for CP0 to sample in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            res_index_reg <= '0;
            res_hi_reg    <= '0;
            res_mask_reg  <= '0;
            res_lo0_reg   <= '0;
            res_lo1_reg   <= '0;
        end else if (state_reg == ST_EXEC) begin
            if (op_reg == OP_TLBP) res_index_reg <= probe_index;
            if (op_reg == OP_TLBR) begin
                res_hi_reg   <= {rd_entry.vpn2, 5'b0, rd_entry.asid};
                res_mask_reg <= {7'b0, rd_entry.mask, 13'b0};
                res_lo0_reg  <= {6'b0, rd_entry.pfn0, rd_entry.c0, rd_entry.d0, rd_entry.v0, rd_entry.g};
                res_lo1_reg  <= {6'b0, rd_entry.pfn1, rd_entry.c1, rd_entry.d1, rd_entry.v1, rd_entry.g};
            end
        end
    end

    // Register both translations; outputs stay zero on cycles without a request
    always_ff @(posedge clk) begin
        if (rst) begin
            i_valid_reg <= 1'b0;
            d_valid_reg <= 1'b0;
            i_x_reg     <= '0;
            d_x_reg     <= '0;
        end else begin
            i_valid_reg <= i_req_i;
            d_valid_reg <= d_req_i;
            i_x_reg     <= i_req_i ? tlb_translate(i_vaddr_i, i_res.hit, i_res.pfn, i_res.c,
                                                   i_res.d, i_res.v, 1'b0) : '0;
            d_x_reg     <= d_req_i ? tlb_translate(d_vaddr_i, d_res.hit, d_res.pfn, d_res.c,
                                                   d_res.d, d_res.v, d_store_i) : '0;
        end
    end

    assign random_o          = random_reg;
    assign result_index_o    = res_index_reg;
    assign result_entryhi_o  = res_hi_reg;
    assign result_pagemask_o = res_mask_reg;
    assign result_entrylo0_o = res_lo0_reg;
    assign result_entrylo1_o = res_lo1_reg;
    assign i_valid_o         = i_valid_reg;
    assign d_valid_o         = d_valid_reg;
    assign i_paddr_o         = i_x_reg.paddr;
    assign d_paddr_o         = d_x_reg.paddr;
    assign i_refill_o        = i_x_reg.refill;
    assign d_refill_o        = d_x_reg.refill;
    assign i_invalid_o       = i_x_reg.invalid;
    assign d_invalid_o       = d_x_reg.invalid;
    assign d_modified_o      = d_x_reg.modified;
    assign i_cached_o        = i_x_reg.cached;
    assign d_cached_o        = d_x_reg.cached;

    // CP0 fields that carry no state here, and match outputs a given port ignores
    logic unused_ok;
    assign unused_ok = ^{index_i[31:TLB_WIDTH], entryhi_i[12:8], pagemask_i[31:25],
                         pagemask_i[12:0], entrylo0_i[31:26], entrylo1_i[31:26],
                         probe_res.pfn, probe_res.c, probe_res.d, probe_res.v,
                         probe_res.idx[IDX_W-1:TLB_WIDTH], i_res.idx, d_res.idx,
                         i_x_reg.modified};

endmodule

// File: tb/tb_tlb_unit.sv
// Randomized bench for tlb_unit against an array-based reference of the TLB.
module tb_tlb_unit;

    localparam logic [1:0] OP_R = 2'd0, OP_WI = 2'd1, OP_WR = 2'd2, OP_P = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [1:0]  op;
    logic        busy, op_done;
    logic [31:0] index, entryhi, pagemask, entrylo0, entrylo1;
    logic        result_we, result_index_we;
    logic [31:0] result_index, result_entryhi, result_pagemask, result_entrylo0, result_entrylo1;
    logic [4:0]  random;
    logic        i_req, d_req, d_store;
    logic [31:0] i_vaddr, d_vaddr, i_paddr, d_paddr;
    logic        i_valid, d_valid, i_refill, d_refill, i_invalid, d_invalid;
    logic        d_modified, i_cached, d_cached;

    always #5 clk = ~clk;

    tlb_unit #(.TLB_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .op_valid_i(op_valid), .op_i(op), .busy_o(busy), .op_done_o(op_done),
        .index_i(index), .entryhi_i(entryhi), .pagemask_i(pagemask),
        .entrylo0_i(entrylo0), .entrylo1_i(entrylo1),
        .result_we_o(result_we), .result_index_we_o(result_index_we),
        .result_index_o(result_index), .result_entryhi_o(result_entryhi),
        .result_pagemask_o(result_pagemask), .result_entrylo0_o(result_entrylo0),
        .result_entrylo1_o(result_entrylo1), .random_o(random),
        .i_req_i(i_req), .d_req_i(d_req), .i_vaddr_i(i_vaddr), .d_vaddr_i(d_vaddr),
        .d_store_i(d_store), .i_paddr_o(i_paddr), .d_paddr_o(d_paddr),
        .i_valid_o(i_valid), .d_valid_o(d_valid), .i_refill_o(i_refill), .d_refill_o(d_refill),
        .i_invalid_o(i_invalid), .d_invalid_o(d_invalid), .d_modified_o(d_modified),
        .i_cached_o(i_cached), .d_cached_o(d_cached)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [31:0] last_index;

    // Cycles since reset release; the random counter is 31 minus this, mod 32
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Reference TLB: entry fields kept as plain arrays, EntryLo stored as bits [25:1]
    logic [18:0] m_vpn2 [32];
    logic [7:0]  m_asid [32];
    logic        m_g    [32];
    logic [11:0] m_mask [32];
    logic [24:0] m_lo   [32][2];
    logic [18:0] pool   [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            m_vpn2[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0; m_mask[i] = '0;
            m_lo[i][0] = '0; m_lo[i][1] = '0;
        end
    endtask

    function automatic int exp_random();
        return 31 - (cyc % 32);
    endfunction

    function automatic int m_find(input logic [31:0] hi);
        for (int i = 0; i < 32; i++)
            if (m_vpn2[i] == hi[31:13] && (m_g[i] || m_asid[i] == hi[7:0])) return i;
        return -1;
    endfunction

    // Expected translation; fl = {refill, invalid, modified, cached}
    task automatic m_xlate(input logic [31:0] va, input logic [7:0] asid, input logic st,
                           output logic [31:0] pa, output logic [3:0] fl);
        int k;
        logic [31:0] lo, pfn;
        logic [2:0]  c;
        pa = '0;
        fl = '0;
        if (va[31:30] == 2'b10) begin
            pa    = va & 32'h1FFF_FFFF;
            fl[0] = ~va[29];
        end else begin
            k = m_find({va[31:13], 5'd0, asid});
            if (k < 0) fl[3] = 1'b1;
            else begin
                lo    = {6'd0, m_lo[k][va[12]], 1'b0};
                pfn   = lo >> 6;
                c     = lo[5:3];
                pa    = (pfn << 12) | (va & 32'h0000_0FFF);
                fl[2] = ~lo[1];
                fl[1] = lo[1] & st & ~lo[2];
                fl[0] = (c == 3'd3);
            end
        end
    endtask

    task automatic lookup(input logic [31:0] iva, input logic [31:0] dva,
                          input logic [7:0] asid, input logic st);
        logic [31:0] ipa, dpa;
        logic [3:0]  ifl, dfl;
        @(negedge clk);
        i_req = 1'b1; d_req = 1'b1; i_vaddr = iva; d_vaddr = dva; d_store = st;
        entryhi = {24'($urandom), asid};
        m_xlate(iva, asid, 1'b0, ipa, ifl);
        m_xlate(dva, asid, st, dpa, dfl);
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0;
        $display("lookup asid=%0d i=%08h->%08h fl=%b d=%08h st=%0d ->%08h fl=%b",
                 asid, iva, i_paddr, {i_refill, i_invalid, 1'b0, i_cached},
                 dva, st, d_paddr, {d_refill, d_invalid, d_modified, d_cached});
        check("i_valid", 32'(i_valid), 32'd1);
        check("d_valid", 32'(d_valid), 32'd1);
        check("i_paddr", i_paddr, ipa);
        check("d_paddr", d_paddr, dpa);
        check("i_flags", 32'({i_refill, i_invalid, 1'b0, i_cached}), 32'(ifl));
        check("d_flags", 32'({d_refill, d_invalid, d_modified, d_cached}), 32'(dfl));
    endtask

    // One CP0 op; 'spam' keeps op_valid high while busy, 'abort' resets during EXEC
    task automatic do_op(input logic [1:0] o, input logic [31:0] idx, input logic [31:0] hi,
                         input logic [31:0] pm, input logic [31:0] lo0, input logic [31:0] lo1,
                         input bit abort, input bit spam);
        int tgt, k;
        logic [31:0] e_idx, e_hi, e_pm, e_lo0, e_lo1, dva, dpa;
        logic [3:0]  dfl;
        @(negedge clk);
        for (int n = 0; n < 8 && busy; n++) @(negedge clk);
        check("idle_before_op", 32'(busy), 32'd0);
        check("random", 32'(random), 32'(exp_random()));
        tgt = (o == OP_WR) ? exp_random() : int'(idx[4:0]);
        op_valid = 1'b1; op = o; index = idx; entryhi = hi; pagemask = pm;
        entrylo0 = lo0; entrylo1 = lo1;
        @(negedge clk);   // EXEC
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_done", 32'(op_done), 32'd0);
        if (spam) begin
            op = OP_WI; index = 32'd9; entryhi = $urandom; entrylo0 = $urandom; entrylo1 = $urandom;
        end else begin
            op_valid = 1'b0;
        end
        k     = m_find(hi);
        e_idx = (k < 0) ? 32'h8000_0000 : 32'(k);
        e_hi  = {m_vpn2[tgt], 5'd0, m_asid[tgt]};
        e_pm  = {7'd0, m_mask[tgt], 13'd0};
        e_lo0 = {6'd0, m_lo[tgt][0], m_g[tgt]};
        e_lo1 = {6'd0, m_lo[tgt][1], m_g[tgt]};
        // concurrent lookup must see the entry as it was before this op's write
        dva     = {m_vpn2[tgt], 13'($urandom)};
        d_req   = 1'b1; d_vaddr = dva; d_store = 1'b1;
        m_xlate(dva, entryhi[7:0], 1'b1, dpa, dfl);
        if (abort) rst = 1'b1;
        @(negedge clk);   // DONE, or back in IDLE after an abort
        d_req = 1'b0;
        $display("op=%0d tgt=%0d hi=%08h lo0=%08h lo1=%08h abort=%0d spam=%0d done=%0d we=%0d",
                 o, tgt, hi, lo0, lo1, abort, spam, op_done, result_we);
        if (abort) begin
            check("abort_done", 32'(op_done), 32'd0);
            check("abort_we", 32'(result_we), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            rst = 1'b0;
            m_clear();
            return;
        end
        check("op_done", 32'(op_done), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        check("result_we", 32'(result_we), 32'((o == OP_R) || (o == OP_P)));
        check("result_index_we", 32'(result_index_we), 32'(o == OP_P));
        check("cc_d_paddr", d_paddr, dpa);
        check("cc_d_flags", 32'({d_refill, d_invalid, d_modified, d_cached}), 32'(dfl));
        if (o == OP_P) begin
            last_index = result_index;
            check("tlbp_index", result_index, e_idx);
        end
        if (o == OP_R) begin
            check("tlbr_entryhi", result_entryhi, e_hi);
            check("tlbr_pagemask", result_pagemask, e_pm);
            check("tlbr_lo0", result_entrylo0, e_lo0);
            check("tlbr_lo1", result_entrylo1, e_lo1);
        end
        if (o == OP_WI || o == OP_WR) begin
            m_vpn2[tgt]  = hi[31:13];
            m_asid[tgt]  = hi[7:0];
            m_mask[tgt]  = pm[24:13];
            m_lo[tgt][0] = lo0[25:1];
            m_lo[tgt][1] = lo1[25:1];
            m_g[tgt]     = lo0[0] & lo1[0];
        end
        @(negedge clk);   // IDLE again
        op_valid = 1'b0;
        check("after_busy", 32'(busy), 32'd0);
        check("after_done", 32'(op_done), 32'd0);
    endtask

    function automatic logic [31:0] rand_hi();
        return {pool[$urandom % 4], 5'($urandom), 8'($urandom % 4)};
    endfunction

    function automatic logic [31:0] rand_va();
        logic [2:0] seg;
        if ($urandom % 6 == 0) begin
            seg = ($urandom % 2 == 0) ? 3'b100 : 3'b101;
            return {seg, 29'($urandom)};
        end
        return {pool[$urandom % 4], 13'($urandom)};
    endfunction

    initial begin
        pool[0] = 19'h00200; pool[1] = 19'h00001; pool[2] = 19'h60000; pool[3] = 19'h3ABCD;
        m_clear();
        rst = 1'b1; op_valid = 1'b0; op = '0; index = '0; entryhi = '0; pagemask = '0;
        entrylo0 = '0; entrylo1 = '0; i_req = 1'b0; d_req = 1'b0; i_vaddr = '0; d_vaddr = '0;
        d_store = 1'b0; last_index = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state and free-running random counter
        check("rst_random", 32'(random), 32'd31);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'({result_we, result_index_we, op_done}), 32'd0);
        check("rst_valid", 32'({i_valid, d_valid}), 32'd0);
        check("rst_result_index", result_index, 32'd0);
        @(negedge clk);
        check("random_30", 32'(random), 32'd30);
        @(negedge clk);
        check("random_29", 32'(random), 32'd29);

        // probe of an empty TLB misses
        do_op(OP_P, 0, 32'h0040_0001, 0, 0, 0, 0, 0);
        check("tlbp_miss", last_index, 32'h8000_0000);

        // write then read back index 3
        do_op(OP_WI, 3, 32'h0040_0005, 32'h0000_0000, 32'h0000_1016, 32'h0000_2016, 0, 0);
        do_op(OP_R, 3, 0, 0, 0, 0, 0, 0);

        // mapped lookups on the odd half, matching and mismatching ASID
        lookup(32'h0040_1ABC, 32'h0040_1ABC, 8'd5, 1'b1);
        lookup(32'h0040_1ABC, 32'h0040_1ABC, 8'd6, 1'b1);

        // invalid, then modified, then a clean load on a cacheable page
        do_op(OP_WI, 3, 32'h0040_0005, 0, 32'h0000_1014, 32'h0000_2016, 0, 0);
        lookup(32'h0040_0000, 32'h0040_0000, 8'd5, 1'b0);
        do_op(OP_WI, 3, 32'h0040_0005, 0, 32'h0000_101A, 32'h0000_2016, 0, 0);
        lookup(32'h0040_0010, 32'h0040_0010, 8'd5, 1'b1);
        lookup(32'h0040_0010, 32'h0040_0010, 8'd5, 1'b0);

        // unmapped segments
        lookup(32'h8000_1234, 32'hA000_1234, 8'd0, 1'b0);
        check("kseg0_paddr", i_paddr, 32'h0000_1234);
        check("kseg1_paddr", d_paddr, 32'h0000_1234);

        // TLBWR lands on the random index, TLBP finds it
        for (int n = 0; n < 40 && random != 5'd18; n++) @(negedge clk);
        do_op(OP_WR, 0, 32'h00C0_0007, 32'h01FF_E000, 32'h0000_3F1F, 32'h0000_4017, 0, 0);
        do_op(OP_P, 0, 32'h00C0_0007, 0, 0, 0, 0, 0);
        check("tlbwr_idx17", last_index, 32'd17);

        // op_valid held during busy must not start a second op (would hit index 9)
        do_op(OP_R, 3, 0, 0, 0, 0, 0, 1);
        do_op(OP_R, 9, 0, 0, 0, 0, 0, 0);

        // reset during EXEC of a write: no completion, TLB cleared
        do_op(OP_WI, 5, 32'h0040_0005, 0, 32'h0000_1016, 32'h0000_1017, 1, 0);
        do_op(OP_R, 5, 0, 0, 0, 0, 0, 0);
        do_op(OP_R, 3, 0, 0, 0, 0, 0, 0);

        // randomized mix of ops and lookups
        for (int t = 0; t < 160; t++) begin
            if ($urandom % 2 == 0)
                do_op(2'($urandom % 4), 32'($urandom % 32), rand_hi(), $urandom,
                      $urandom, $urandom, 0, ($urandom % 8) == 0);
            else
                lookup(rand_va(), rand_va(), 8'($urandom % 4), 1'($urandom % 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
